// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-bus responder: FSM states, captured request, lane count.
package mem_bus_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_bus_state_t;

  typedef struct packed {
    logic [31:0]           addr;
    logic [31:0]           wr_data;
    logic [BYTE_LANES-1:0] byte_en;
    logic                  wr_en;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_storage.sv
// Word array with per-lane write enables and a registered read port; one access per access_en pulse.
// Read register clears on reset and returns 0 for writes or killed accesses; contents are never reset.
module mem_bus_storage
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  access_en,
  input  logic                  access_kill,
  input  logic                  wr_en,
  input  logic [BYTE_LANES-1:0] byte_en,
  input  logic [ADDR_WIDTH-3:0] idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (access_en) begin
      rd_data_d = (wr_en || access_kill) ? '0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // A write landing on a reset edge is dropped along with the rest of the transaction.
  always_ff @(posedge clk) begin
    if (access_en && wr_en && !access_kill && !rst) begin
      for (int k = 0; k < BYTE_LANES; k++) begin
        if (byte_en[k]) begin
          mem_q[idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Load/store responder: one request at a time, response valid LATENCY+1 edges after accept; optional MEM_BUS_ERR_EN.
// Request side stalls (ready low) outside IDLE; response is held stable until rsp_ready_i.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_wr_en_i,
  input  logic [BYTE_LANES-1:0] req_byte_en_i,
  input  logic [DATA_WIDTH-1:0] req_wr_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rd_data_o,
  output logic                  rsp_err_o
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY);

  mem_bus_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  mem_req_t       req_q, req_d;
  logic           err_q, err_d;
  logic           access_en;
  logic           out_of_range;

`ifdef MEM_BUS_ERR_EN
  assign out_of_range = |req_q.addr[31:ADDR_WIDTH];
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_q.addr[1:0];
`else
  assign out_of_range = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_q.addr[31:ADDR_WIDTH], req_q.addr[1:0]};
`endif

  assign req_ready_o = (state_q == IDLE) & ~rst;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    err_d     = err_q;
    access_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          req_d.addr    = req_addr_i;
          req_d.wr_data = req_wr_data_i;
          req_d.byte_en = req_byte_en_i;
          req_d.wr_en   = req_wr_en_i;
          cnt_d         = CNT_INIT;
          state_d       = WAIT;
        end
      end
      // cnt reaching zero marks the access cycle; LATENCY=0 goes straight to it.
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access_en = 1'b1;
          err_d     = out_of_range;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
    cnt_q <= cnt_d;
    req_q <= req_d;
  end

  mem_bus_storage #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_storage (
    .clk         (clk),
    .rst         (rst),
    .access_en   (access_en),
    .access_kill (out_of_range),
    .wr_en       (req_q.wr_en),
    .byte_en     (req_q.byte_en),
    .idx         (req_q.addr[ADDR_WIDTH-1:2]),
    .wr_data     (req_q.wr_data),
    .rd_data     (rsp_rd_data_o)
  );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: LATENCY=2 instance (dut a) and LATENCY=0 instance (dut b) sharing request/response inputs.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic [31:0] req_addr;
  logic        req_wr_en;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic        ready_a, valid_a, err_a;
  logic        ready_b, valid_b, err_b;
  logic [31:0] rd_a, rd_b;

  logic        sel;
  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_a), .req_ready_o(ready_a), .req_addr_i(req_addr),
    .req_wr_en_i(req_wr_en), .req_byte_en_i(req_be), .req_wr_data_i(req_wdata),
    .rsp_valid_o(valid_a), .rsp_ready_i(rsp_ready), .rsp_rd_data_o(rd_a), .rsp_err_o(err_a)
  );

  mem_bus_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_b), .req_ready_o(ready_b), .req_addr_i(req_addr),
    .req_wr_en_i(req_wr_en), .req_byte_en_i(req_be), .req_wr_data_i(req_wdata),
    .rsp_valid_o(valid_b), .rsp_ready_i(rsp_ready), .rsp_rd_data_o(rd_b), .rsp_err_o(err_b)
  );

  assign obs_ready = sel ? ready_b : ready_a;
  assign obs_valid = sel ? valid_b : valid_a;
  assign obs_rd    = sel ? rd_b    : rd_a;
  assign obs_err   = sel ? err_b   : err_a;

`ifdef MEM_BUS_ERR_EN
  localparam logic        EXP_OOR_ERR  = 1'b1;
  localparam logic [31:0] EXP_ALIAS_RD = 32'h0123_4567;
`else
  localparam logic        EXP_OOR_ERR  = 1'b0;
  localparam logic [31:0] EXP_ALIAS_RD = 32'hCAFE_F00D;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full transaction on the selected instance with rsp_ready held high.
  task automatic txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    int n;
    chk({tag, " req_ready"}, 32'(obs_ready), 32'd1);
    req_wr_en = we; req_addr = a; req_be = be; req_wdata = wd;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    n = 0;
    while (!obs_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), sel ? 32'd1 : 32'd3);
    chk({tag, " rd_data"}, obs_rd, exp_rd);
    chk({tag, " err"}, 32'(obs_err), 32'(exp_err));
    tick();
    chk({tag, " valid_drop"}, 32'(obs_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_addr = '0; req_wr_en = 1'b0; req_be = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    tick(); tick();
    chk("rst rsp_valid", 32'(valid_a), 32'd0);
    chk("rst rd_data", rd_a, 32'd0);
    chk("rst err", 32'(err_a), 32'd0);
    chk("rst req_ready", 32'(ready_a), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst req_ready", 32'(ready_a), 32'd1);

    // Writes and reads with lane enables
    txn(1'b1, 32'h10, 4'hF, 32'hA5A5_1234, 32'h0, 1'b0, "wr full");
    txn(1'b0, 32'h10, 4'h0, 32'h0,         32'hA5A5_1234, 1'b0, "rd full");
    txn(1'b1, 32'h10, 4'h1, 32'h0000_00FF, 32'h0, 1'b0, "wr lane0");
    txn(1'b0, 32'h10, 4'h0, 32'h0,         32'hA5A5_12FF, 1'b0, "rd lane0");
    txn(1'b1, 32'h10, 4'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr be0");
    txn(1'b0, 32'h10, 4'hF, 32'h0,         32'hA5A5_12FF, 1'b0, "rd be0");
    txn(1'b1, 32'h12, 4'hA, 32'h1122_3344, 32'h0, 1'b0, "wr lanes13");
    txn(1'b0, 32'h13, 4'h0, 32'h0,         32'h11A5_33FF, 1'b0, "rd lanes13");

    // Response backpressure with a competing request held on the channel
    rsp_ready = 1'b0;
    req_wr_en = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick(); tick(); tick();
    chk("bp valid rise", 32'(valid_a), 32'd1);
    req_wr_en = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0;
    req_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp valid", 32'(valid_a), 32'd1);
      chk("bp rd_data", rd_a, 32'h11A5_33FF);
      chk("bp req_ready", 32'(ready_a), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid_a = 1'b0;
    tick();
    chk("bp release valid", 32'(valid_a), 32'd0);
    chk("bp release ready", 32'(ready_a), 32'd1);
    txn(1'b0, 32'h10, 4'h0, 32'h0, 32'h11A5_33FF, 1'b0, "bp no write");

    // Reset during WAIT of a write
    txn(1'b1, 32'h20, 4'hF, 32'h1111_1111, 32'h0, 1'b0, "wr 0x20");
    req_wr_en = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h2222_2222;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid-rst req_ready", 32'(ready_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid-rst no rsp", 32'(valid_a), 32'd0);
    end
    txn(1'b0, 32'h20, 4'h0, 32'h0, 32'h1111_1111, 1'b0, "rd 0x20");

    // Address above the decoded range
    txn(1'b1, 32'h000,  4'hF, 32'h0123_4567, 32'h0, 1'b0, "wr 0x000");
    txn(1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, 32'h0, EXP_OOR_ERR, "wr 0x1000");
    txn(1'b0, 32'h000,  4'h0, 32'h0, EXP_ALIAS_RD, 1'b0, "rd 0x000");

    // Zero-latency instance, back-to-back transactions
    sel = 1'b1;
    txn(1'b1, 32'h40, 4'hF, 32'h8765_4321, 32'h0, 1'b0, "L0 wr a");
    txn(1'b1, 32'h44, 4'hC, 32'hBEEF_0000, 32'h0, 1'b0, "L0 wr b");
    txn(1'b0, 32'h40, 4'h0, 32'h0, 32'h8765_4321, 1'b0, "L0 rd a");
    txn(1'b1, 32'h44, 4'h3, 32'h0000_CAFE, 32'h0, 1'b0, "L0 wr c");
    txn(1'b0, 32'h44, 4'h0, 32'h0, 32'hBEEF_CAFE, 1'b0, "L0 rd b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
